pll_reconf_seq: RTL and testbench

Sequencer that retunes the Cyclone V fractional video/system PLL between two clock profiles at run time. It sits between core control logic (region select) and the `altera_pll_reconfig` management port, which drives the PLL's `reconfig_to_pll`/`reconfig_from_pll` bus. On request it issues a fixed Avalon-MM write sequence (mode, M, K, C0–C2, start), waits for relock, and reports completion or timeout.

---
 rtl/pll_reconf_pkg.sv | 45 ++++
 rtl/pll_reconf_if.sv | 25 ++
 rtl/pll_reconf_seq.sv | 201 ++++++++++++++++++++
 tb/tb_pll_reconf_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconf_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
// Holds the state encoding, the management register map and both clock profiles.
package pll_reconf_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_LOCK_FALL,
        ST_LOCK_RISE,
        ST_FINISH
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_MODE  = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_START = 6'h02;
    localparam logic [ADDR_W-1:0] ADDR_M     = 6'h04;
    localparam logic [ADDR_W-1:0] ADDR_C     = 6'h05;
    localparam logic [ADDR_W-1:0] ADDR_K     = 6'h07;

    localparam logic [2:0]        LAST_IDX   = 3'd6;
    localparam logic [DATA_W-1:0] START_WORD = 32'h0000_0001;

    // Counter words carry the C-counter number in [22:18] above the
    // odd-duty/bypass/high/low fields.
    localparam int CSEL_LSB = 18;

    function automatic logic [DATA_W-1:0] cntSel(input logic [4:0] sel);
        return DATA_W'(sel) << CSEL_LSB;
    endfunction

    // Per profile: mode, M, K, C0, C1, C2.
    localparam logic [DATA_W-1:0] PROFILE_DATA [2][6] = '{
        '{32'h0000_0000, 32'h0000_0404, 32'h8336_557D,
          32'h0000_0202 | cntSel(5'd0),
          32'h0000_0404 | cntSel(5'd1),
          32'h0000_0808 | cntSel(5'd2)},
        '{32'h0000_0000, 32'h0000_0505, 32'h147A_E148,
          32'h0000_0303 | cntSel(5'd0),
          32'h0002_0605 | cntSel(5'd1),
          32'h0000_0A0A | cntSel(5'd2)}
    };

endpackage

// File: rtl/pll_reconf_if.sv
// Avalon-MM write port between the sequencer (master) and the
// altera_pll_reconfig management slave.
interface pll_reconf_if;
    import pll_reconf_pkg::*;

    logic [ADDR_W-1:0] mgmt_address;
    logic              mgmt_write;
    logic [DATA_W-1:0] mgmt_writedata;
    logic              mgmt_waitrequest;

    modport master (
        output mgmt_address,
        output mgmt_write,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address,
        input  mgmt_write,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );

endinterface

// File: rtl/pll_reconf_seq.sv
// Retunes the PLL between two profiles through the reconfig management port.
// Define PLL_RECONF_LOCK_WAIT_EN to wait for the PLL to drop and regain lock.
module pll_reconf_seq
    import pll_reconf_pkg::*;
#(
    parameter int LOCK_TIMEOUT   = 1_000_000,
    parameter int LOCK_FALL_WAIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              profile_i,
    input  logic              pll_locked_i,
    pll_reconf_if.master      mgmt,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o
);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       prof_q, prof_d;
    logic       pend_q, pend_d;
    logic       pendProf_q, pendProf_d;
    logic       done_q, done_d;
    logic       writeAck;

`ifdef PLL_RECONF_LOCK_WAIT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] FALL_LIM = CNT_W'(LOCK_FALL_WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d, cntNext;
    logic             timeout_q, timeout_d;

    assign cntNext = (cnt_q == TO_LIM) ? cnt_q : cnt_q + CNT_W'(1);
`else
    logic unusedLock;
    assign unusedLock = pll_locked_i | (LOCK_TIMEOUT == 0) | (LOCK_FALL_WAIT == 0);
`endif

    assign writeAck = (state_q == ST_WRITE) && !mgmt.mgmt_waitrequest;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        prof_d     = prof_q;
        pend_d     = pend_q;
        pendProf_d = pendProf_q;
        done_d     = 1'b0;
`ifdef PLL_RECONF_LOCK_WAIT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif

        // Requests arriving mid-sequence collapse into one pending retune.
        if (state_q != ST_IDLE && req_i) begin
            pend_d     = 1'b1;
            pendProf_d = profile_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    prof_d  = profile_i;
                    pend_d  = 1'b0;
                    idx_d   = 3'd0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (writeAck) begin
                    if (idx_q == LAST_IDX) begin
`ifdef PLL_RECONF_LOCK_WAIT_EN
                        cnt_d   = '0;
                        state_d = ST_LOCK_FALL;
`else
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef PLL_RECONF_LOCK_WAIT_EN
            ST_LOCK_FALL: begin
                cnt_d = cntNext;
                if (!pll_locked_i || cnt_q == FALL_LIM) begin
                    state_d = ST_LOCK_RISE;
                end
            end
            ST_LOCK_RISE: begin
                cnt_d = cntNext;
                if (pll_locked_i) begin
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else if (cnt_q == TO_LIM) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                if (req_i) begin
                    prof_d  = profile_i;
                    pend_d  = 1'b0;
                    idx_d   = 3'd0;
                    state_d = ST_WRITE;
                end else if (pend_q) begin
                    prof_d  = pendProf_q;
                    pend_d  = 1'b0;
                    idx_d   = 3'd0;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            prof_q     <= 1'b0;
            pend_q     <= 1'b0;
            pendProf_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef PLL_RECONF_LOCK_WAIT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            prof_q     <= prof_d;
            pend_q     <= pend_d;
            pendProf_q <= pendProf_d;
            done_q     <= done_d;
`ifdef PLL_RECONF_LOCK_WAIT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    // Bus outputs decode from registered state only, so they stay stable under stall.
    always_comb begin
        mgmt.mgmt_write     = (state_q == ST_WRITE);
        mgmt.mgmt_address   = '0;
        mgmt.mgmt_writedata = '0;
        if (state_q == ST_WRITE) begin
            case (idx_q)
                3'd0: begin
                    mgmt.mgmt_address   = ADDR_MODE;
                    mgmt.mgmt_writedata = PROFILE_DATA[prof_q][0];
                end
                3'd1: begin
                    mgmt.mgmt_address   = ADDR_M;
                    mgmt.mgmt_writedata = PROFILE_DATA[prof_q][1];
                end
                3'd2: begin
                    mgmt.mgmt_address   = ADDR_K;
                    mgmt.mgmt_writedata = PROFILE_DATA[prof_q][2];
                end
                3'd3: begin
                    mgmt.mgmt_address   = ADDR_C;
                    mgmt.mgmt_writedata = PROFILE_DATA[prof_q][3];
                end
                3'd4: begin
                    mgmt.mgmt_address   = ADDR_C;
                    mgmt.mgmt_writedata = PROFILE_DATA[prof_q][4];
                end
                3'd5: begin
                    mgmt.mgmt_address   = ADDR_C;
                    mgmt.mgmt_writedata = PROFILE_DATA[prof_q][5];
                end
                3'd6: begin
                    mgmt.mgmt_address   = ADDR_START;
                    mgmt.mgmt_writedata = START_WORD;
                end
                default: begin
                    mgmt.mgmt_address   = '0;
                    mgmt.mgmt_writedata = '0;
                end
            endcase
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;

`ifdef PLL_RECONF_LOCK_WAIT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reconf_seq.sv
// Directed bench for pll_reconf_seq; expected write lists are hand tables below.
// Lock-wait timings are checked when PLL_RECONF_LOCK_WAIT_EN is defined.
module tb_pll_reconf_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic profile = 1'b0;
    logic waitreq;
    logic busy, done, timeout;
    logic stallEn = 1'b0;
    logic forceStall = 1'b0;
    logic lockReturn = 1'b1;
    int   stallRun = 0;

`ifdef PLL_RECONF_LOCK_WAIT_EN
    logic pllLocked = 1'b1;
`else
    logic pllLocked = 1'b0;
`endif

    int testsRun = 0;
    int failCount = 0;
    int doneCnt = 0;
    int toCnt = 0;
    int accTotal = 0;
    int wrPos = 0;
    bit profQ[$];
    event startAck;

    logic [5:0]  addrTab [7] = '{6'h00, 6'h04, 6'h07, 6'h05, 6'h05, 6'h05, 6'h02};
    logic [31:0] dataA   [7] = '{32'h0, 32'h0000_0404, 32'h8336_557D, 32'h0000_0202,
                                 32'h0004_0404, 32'h0008_0808, 32'h1};
    logic [31:0] dataB   [7] = '{32'h0, 32'h0000_0505, 32'h147A_E148, 32'h0000_0303,
                                 32'h0006_0605, 32'h0008_0A0A, 32'h1};

    pll_reconf_if mgmtIf ();
    assign mgmtIf.mgmt_waitrequest = waitreq;

    pll_reconf_seq #(.LOCK_TIMEOUT(100), .LOCK_FALL_WAIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .profile_i    (profile),
        .pll_locked_i (pllLocked),
        .mgmt         (mgmtIf.master),
        .busy_o       (busy),
        .done_o       (done),
        .timeout_o    (timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Stall generator: runs of at most four waitrequest cycles.
    initial waitreq = 1'b0;
    always @(posedge clk) begin
        #2;
        if (stallEn && stallRun < 4 && $urandom_range(0, 1) == 1) begin
            waitreq = 1'b1;
            stallRun++;
        end else begin
            waitreq = forceStall;
            stallRun = 0;
        end
    end

    // Every cycle with the strobe up must show the next expected list entry.
    always @(negedge clk) begin
        if (mgmtIf.mgmt_write) begin
            if (profQ.size() == 0) begin
                checkOutput("unexpectedWrite", 32'd1, 32'd0);
            end else begin
                checkOutput("wrAddr", 32'(mgmtIf.mgmt_address), 32'(addrTab[wrPos]));
                checkOutput("wrData", mgmtIf.mgmt_writedata,
                            profQ[0] ? dataB[wrPos] : dataA[wrPos]);
                if (!waitreq) begin
                    accTotal++;
                    wrPos++;
                    if (wrPos == 7) begin
                        wrPos = 0;
                        void'(profQ.pop_front());
                        -> startAck;
                    end
                end
            end
        end
        if (done) doneCnt++;
        if (timeout) toCnt++;
        if (done && timeout) checkOutput("doneAndTimeout", 32'd1, 32'd0);
    end

`ifdef PLL_RECONF_LOCK_WAIT_EN
    always begin
        @(startAck);
        repeat (5) @(posedge clk);
        #1 pllLocked = 1'b0;
        if (lockReturn) begin
            repeat (40) @(posedge clk);
            #1 pllLocked = 1'b1;
        end
    end
`endif

    task automatic applyStimulus(input logic prof);
        @(posedge clk);
        #1;
        req = 1'b1;
        profile = prof;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int n, output bit gotDone);
        n = 0;
        gotDone = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done || timeout) begin
                n = i;
                gotDone = done;
                break;
            end
        end
        if (n == 0) checkOutput("waitBudget", 32'd0, 32'd1);
    endtask

    task automatic waitPos(input int pos);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (wrPos == pos) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reachPos", 32'(found), 32'd1);
    endtask

    initial begin
        int  n;
        bit  gotDone;
        int  accStart;
        int  doneStart;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstWrite", 32'(mgmtIf.mgmt_write), 32'd0);
        checkOutput("rstAddr", 32'(mgmtIf.mgmt_address), 32'd0);
        checkOutput("rstData", mgmtIf.mgmt_writedata, 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstTimeout", 32'(timeout), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Profile A, no stalls.
        profQ.push_back(1'b0);
        accStart = accTotal;
        doneStart = doneCnt;
        applyStimulus(1'b0);
        @(negedge clk);
        checkOutput("firstBusy", 32'(busy), 32'd1);
        checkOutput("firstWrite", 32'(mgmtIf.mgmt_write), 32'd1);
        waitDone(300, n, gotDone);
`ifdef PLL_RECONF_LOCK_WAIT_EN
        checkOutput("doneLatencyA", 32'(n), 32'd52);
`else
        checkOutput("doneLatencyA", 32'(n), 32'd7);
`endif
        checkOutput("gotDoneA", 32'(gotDone), 32'd1);
        @(negedge clk);
        checkOutput("busyAfterA", 32'(busy), 32'd0);
        checkOutput("donePulseA", 32'(done), 32'd0);
        checkOutput("writesA", 32'(accTotal - accStart), 32'd7);
        checkOutput("doneCntA", 32'(doneCnt - doneStart), 32'd1);

        // Profile B under random stalls.
        stallEn = 1'b1;
        profQ.push_back(1'b1);
        accStart = accTotal;
        applyStimulus(1'b1);
        waitDone(400, n, gotDone);
        checkOutput("gotDoneStall", 32'(gotDone), 32'd1);
        checkOutput("writesStall", 32'(accTotal - accStart), 32'd7);
        stallEn = 1'b0;
        repeat (3) @(negedge clk);

        // Profile B requested during entry 3 of a profile A run.
        profQ.push_back(1'b0);
        profQ.push_back(1'b1);
        accStart = accTotal;
        doneStart = doneCnt;
        applyStimulus(1'b0);
        waitPos(3);
        req = 1'b1;
        profile = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        waitDone(300, n, gotDone);
        checkOutput("gotDoneFirst", 32'(gotDone), 32'd1);
        waitDone(300, n, gotDone);
        checkOutput("gotDoneSecond", 32'(gotDone), 32'd1);
        @(negedge clk);
        checkOutput("busyAfterPend", 32'(busy), 32'd0);
        checkOutput("writesPend", 32'(accTotal - accStart), 32'd14);
        checkOutput("doneCntPend", 32'(doneCnt - doneStart), 32'd2);

        // Reset while write 2 is stalled, then a fresh run.
        profQ.push_back(1'b0);
        applyStimulus(1'b0);
        waitPos(2);
        forceStall = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstMidWrite", 32'(mgmtIf.mgmt_write), 32'd0);
        checkOutput("rstMidBusy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        forceStall = 1'b0;
        wrPos = 0;
        profQ.delete();
        profQ.push_back(1'b0);
        accStart = accTotal;
        applyStimulus(1'b0);
        @(negedge clk);
        checkOutput("restartAddr", 32'(mgmtIf.mgmt_address), 32'h00);
        waitDone(300, n, gotDone);
        checkOutput("gotDoneRestart", 32'(gotDone), 32'd1);
        checkOutput("writesRestart", 32'(accTotal - accStart), 32'd7);
        repeat (2) @(negedge clk);

`ifdef PLL_RECONF_LOCK_WAIT_EN
        // Lock never returns.
        lockReturn = 1'b0;
        doneStart = doneCnt;
        profQ.push_back(1'b0);
        applyStimulus(1'b0);
        waitDone(300, n, gotDone);
        checkOutput("timeoutLatency", 32'(n), 32'd109);
        checkOutput("timeoutHigh", 32'(timeout), 32'd1);
        checkOutput("noDoneOnTimeout", 32'(doneCnt - doneStart), 32'd0);
        @(negedge clk);
        checkOutput("timeoutPulse", 32'(timeout), 32'd0);
        checkOutput("timeoutCnt", 32'(toCnt), 32'd1);
`else
        checkOutput("timeoutNever", 32'(toCnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
